// File: rtl/ms_slave_arbiter_if.sv
// ms_slave_arbiter_if
//   Bundles the sync/notify bus between NUM_MASTERS blocking masters, the
//   arbiter and the single shared slave.
//   modport master : arbiter view. It drives every *_notify, the data words
//                    and busy, and it samples every *_sync and the inputs.
//   modport slave  : the opposite view, used by the masters and the slave.
// Signals
//   m_req         NUM_MASTERS*DATA_WIDTH  request word per master, master i at [i*DW +: DW]
//   m_req_sync    NUM_MASTERS             master i has a valid request
//   m_req_notify  NUM_MASTERS             request of master i is taken this cycle
//   m_resp        DATA_WIDTH              response word (common bus)
//   m_resp_sync   NUM_MASTERS             master i is ready to accept a response
//   m_resp_notify NUM_MASTERS             response valid for master i
//   m_resp_err    1                       response is a timeout error
//   s_out         DATA_WIDTH              request word to the slave
//   s_out_sync    1                       slave is ready to accept s_out
//   s_out_notify  1                       s_out is valid
//   s_in          DATA_WIDTH              response word from the slave
//   s_in_sync     1                       s_in is valid
//   s_in_notify   1                       arbiter accepts s_in
//   busy          1                       a transaction is in flight
interface ms_slave_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_req;
  logic [NUM_MASTERS-1:0]            m_req_sync;
  logic [NUM_MASTERS-1:0]            m_req_notify;
  logic [DATA_WIDTH-1:0]             m_resp;
  logic [NUM_MASTERS-1:0]            m_resp_sync;
  logic [NUM_MASTERS-1:0]            m_resp_notify;
  logic                              m_resp_err;
  logic [DATA_WIDTH-1:0]             s_out;
  logic                              s_out_sync;
  logic                              s_out_notify;
  logic [DATA_WIDTH-1:0]             s_in;
  logic                              s_in_sync;
  logic                              s_in_notify;
  logic                              busy;

  modport master (
    input  m_req, m_req_sync, m_resp_sync, s_out_sync, s_in, s_in_sync,
    output m_req_notify, m_resp, m_resp_notify, m_resp_err,
           s_out, s_out_notify, s_in_notify, busy
  );

  modport slave (
    output m_req, m_req_sync, m_resp_sync, s_out_sync, s_in, s_in_sync,
    input  m_req_notify, m_resp, m_resp_notify, m_resp_err,
           s_out, s_out_notify, s_in_notify, busy
  );
endinterface

// File: rtl/ms_slave_arbiter.sv
// ms_slave_arbiter
//   Shares one blocking slave among NUM_MASTERS blocking masters. A
//   round-robin pick in IDLE takes one request word, forwards it to the
//   slave, waits for the slave response (bounded by TIMEOUT_CYCLES) and
//   returns it to the granted master. One transaction in flight at a time.
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ms_slave_arbiter_if.master (see the interface for signal meanings)
// Parameters
//   NUM_MASTERS 2..8, DATA_WIDTH, TIMEOUT_CYCLES (0 disables the timeout),
//   ERR_VAL (response word on timeout, sign-extended to DATA_WIDTH)
module ms_slave_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_VAL        = -1
) (
  input logic                clk,
  input logic                rst,
  ms_slave_arbiter_if.master bus
);

  localparam int unsigned NM = NUM_MASTERS;
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] ERR_WORD   = DATA_WIDTH'(ERR_VAL);
  localparam logic [TW-1:0]         TIMER_LAST =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [GW-1:0]         LAST_IDX   = GW'(NM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RESP,
    S_REPLY
  } state_t;

  state_t                 state, state_n;
  logic [GW-1:0]          grant, grant_n;
  logic [GW-1:0]          rr_ptr, rr_ptr_n;
  logic [TW-1:0]          timer, timer_n;
  logic [DATA_WIDTH-1:0]  s_out_q, s_out_n;
  logic [DATA_WIDTH-1:0]  m_resp_q, m_resp_n;
  logic                   err_q, err_n;
  logic [NUM_MASTERS-1:0] req_notify;
  logic [NUM_MASTERS-1:0] resp_notify;
  logic                   found;
  logic [GW-1:0]          pick;
  logic [DATA_WIDTH-1:0]  req_word [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign req_word[g] = bus.m_req[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      timer    <= '0;
      s_out_q  <= '0;
      m_resp_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      rr_ptr   <= rr_ptr_n;
      timer    <= timer_n;
      s_out_q  <= s_out_n;
      m_resp_q <= m_resp_n;
      err_q    <= err_n;
    end
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      logic [GW-1:0] idx;
      idx = GW'((32'(rr_ptr) + i) % NM);
      if (!found && bus.m_req_sync[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    rr_ptr_n   = rr_ptr;
    timer_n    = timer;
    s_out_n    = s_out_q;
    m_resp_n   = m_resp_q;
    err_n      = err_q;
    req_notify = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          req_notify[pick] = 1'b1;
          grant_n          = pick;
          s_out_n          = req_word[pick];
          state_n          = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.s_out_sync) begin
          timer_n = '0;
          state_n = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        // A real response takes priority over a timeout expiring the same cycle.
        if (bus.s_in_sync) begin
          m_resp_n = bus.s_in;
          err_n    = 1'b0;
          state_n  = S_REPLY;
        end else if ((TIMEOUT_CYCLES > 0) && (timer == TIMER_LAST)) begin
          m_resp_n = ERR_WORD;
          err_n    = 1'b1;
          state_n  = S_REPLY;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_REPLY: begin
        if (bus.m_resp_sync[grant]) begin
          rr_ptr_n = (grant == LAST_IDX) ? '0 : grant + 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    resp_notify = '0;
    if (state == S_REPLY) resp_notify[grant] = 1'b1;
  end

  // The request notify is the only combinational output; it is held off
  // during reset so no transfer can be signalled that the state will drop.
  assign bus.m_req_notify  = rst ? '0 : req_notify;
  assign bus.m_resp_notify = resp_notify;
  assign bus.m_resp        = m_resp_q;
  assign bus.m_resp_err    = err_q;
  assign bus.s_out         = s_out_q;
  assign bus.s_out_notify  = (state == S_SEND);
  assign bus.s_in_notify   = (state == S_WAIT_RESP);
  assign bus.busy          = (state != S_IDLE);

endmodule
